// File: rtl/tcdm_banked_responder.sv
// Banked TCDM responder: word-interleaved banks, per-bank round-robin, 1-cycle response.
// Optional TCDM_RESPONDER_STALL_EN masks grants pseudo-randomly via a 16-bit LFSR.

module tcdm_bank #(
  parameter int MP    = 4,
  parameter int DEPTH = 1024,
  parameter int RW    = $clog2(DEPTH),
  parameter int PW    = (MP > 1) ? $clog2(MP) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [MP-1:0]          req,
  input  logic [MP-1:0][RW-1:0]  row,
  input  logic [MP-1:0]          wen,
  input  logic [MP-1:0][3:0]     be,
  input  logic [MP-1:0][31:0]    wdata,
  output logic [MP-1:0]          gnt,
  output logic [31:0]            rdata
);
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rr, sel, idx;
  logic          hit;

  // first requester at or after rr, wrapping
  always_comb begin
    gnt = '0;
    sel = '0;
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < MP; i++) begin
      idx = PW'((int'(rr) + i) % MP);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
    gnt[sel] = hit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)    rr <= '0;
    else if (hit) rr <= (sel == PW'(MP-1)) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (hit && !wen[sel])
      for (int i = 0; i < 4; i++)
        if (be[sel][i]) mem[row[sel]][8*i +: 8] <= wdata[sel][8*i +: 8];
  end

  // asynchronous read so a write followed next cycle by a read sees new data
  assign rdata = mem[row[sel]];
endmodule

module tcdm_banked_responder #(
  parameter int MP    = 4,
  parameter int NB    = 8,
  parameter int DEPTH = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [MP-1:0]        tcdm_req,
  output logic [MP-1:0]        tcdm_gnt,
  input  logic [MP-1:0][31:0]  tcdm_add,
  input  logic [MP-1:0]        tcdm_wen,
  input  logic [MP-1:0][3:0]   tcdm_be,
  input  logic [MP-1:0][31:0]  tcdm_data,
  output logic [MP-1:0][31:0]  tcdm_r_data,
  output logic [MP-1:0]        tcdm_r_valid
);
  localparam int BW = $clog2(NB);
  localparam int RW = $clog2(DEPTH);

  logic [MP-1:0][BW-1:0] bank_sel;
  logic [MP-1:0][RW-1:0] row;
  logic [NB-1:0][MP-1:0] bank_req, bank_gnt;
  logic [NB-1:0][31:0]   bank_rdata;
  logic                  stall;
  logic                  unused_add;

  assign unused_add = ^tcdm_add;

`ifdef TCDM_RESPONDER_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  for (genvar p = 0; p < MP; p++) begin : g_dec
    assign bank_sel[p] = tcdm_add[p][2 +: BW];
    assign row[p]      = tcdm_add[p][2+BW +: RW];
  end

  // masking at the request keeps rr frozen during reset and stall cycles
  for (genvar b = 0; b < NB; b++) begin : g_bank
    for (genvar p = 0; p < MP; p++) begin : g_req
      assign bank_req[b][p] = tcdm_req[p] & (bank_sel[p] == BW'(b)) & ~rst_i & ~stall;
    end
    tcdm_bank #(.MP(MP), .DEPTH(DEPTH)) u_bank (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req   (bank_req[b]),
      .row   (row),
      .wen   (tcdm_wen),
      .be    (tcdm_be),
      .wdata (tcdm_data),
      .gnt   (bank_gnt[b]),
      .rdata (bank_rdata[b])
    );
  end

  always_comb begin
    tcdm_gnt = '0;
    for (int p = 0; p < MP; p++) tcdm_gnt[p] = bank_gnt[bank_sel[p]][p];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tcdm_r_valid <= '0;
      tcdm_r_data  <= '0;
    end else begin
      tcdm_r_valid <= tcdm_gnt;
      for (int p = 0; p < MP; p++)
        if (tcdm_gnt[p]) tcdm_r_data[p] <= tcdm_wen[p] ? bank_rdata[bank_sel[p]] : 32'h0;
    end
  end
endmodule

// File: tb/tb_tcdm_banked_responder.sv
// Self-checking bench for tcdm_banked_responder: directed cases plus randomized traffic vs a word-level model.
module tb_tcdm_banked_responder;
  localparam int MP = 4, NB = 8, DEPTH = 1024;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [MP-1:0]       tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
  logic [MP-1:0][31:0] tcdm_add, tcdm_data, tcdm_r_data;
  logic [MP-1:0][3:0]  tcdm_be;

  int checks = 0, errors = 0;

  always #5 clk_i = ~clk_i;

  tcdm_banked_responder #(.MP(MP), .NB(NB), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt),
    .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen), .tcdm_be(tcdm_be), .tcdm_data(tcdm_data),
    .tcdm_r_data(tcdm_r_data), .tcdm_r_valid(tcdm_r_valid)
  );

  // reference model: flat word store and per-bank pointers
  logic [31:0]         mmem [int];
  int                  rr [NB];
  logic [MP-1:0]       exp_gnt, gnt_obs, exp_rv, rv_obs;
  logic [MP-1:0][31:0] exp_rd, rd_obs;

  function automatic int bank_of(logic [31:0] a);
    return int'((a >> 2) % NB);
  endfunction

  function automatic int word_of(logic [31:0] a);
    return int'((a >> 2) % (NB * DEPTH));
  endfunction

  function automatic logic [MP-1:0] model_gnt();
    logic [MP-1:0] g;
    int p;
    g = '0;
    if (rst_i) return g;
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < MP; k++) begin
        p = (rr[b] + k) % MP;
        if (tcdm_req[p] && bank_of(tcdm_add[p]) == b) begin
          g[p] = 1'b1;
          break;
        end
      end
    return g;
  endfunction

  task automatic tick();
    logic [MP-1:0] g;
    logic [31:0]   v;
    int            w;
    @(negedge clk_i);
    gnt_obs = tcdm_gnt;
    g = model_gnt();
    exp_gnt = g;
    @(posedge clk_i);
    if (rst_i) begin
      exp_rv = '0;
      exp_rd = '0;
      for (int b = 0; b < NB; b++) rr[b] = 0;
    end else begin
      for (int p = 0; p < MP; p++)
        if (g[p] && tcdm_wen[p]) begin
          w = word_of(tcdm_add[p]);
          exp_rd[p] = mmem.exists(w) ? mmem[w] : 32'h0;
        end
      for (int p = 0; p < MP; p++)
        if (g[p]) begin
          if (!tcdm_wen[p]) begin
            w = word_of(tcdm_add[p]);
            v = mmem.exists(w) ? mmem[w] : 32'h0;
            for (int i = 0; i < 4; i++)
              if (tcdm_be[p][i]) v[8*i +: 8] = tcdm_data[p][8*i +: 8];
            mmem[w] = v;
            exp_rd[p] = 32'h0;
          end
          rr[bank_of(tcdm_add[p])] = (p + 1) % MP;
        end
      exp_rv = g;
    end
    #1;
    rv_obs = tcdm_r_valid;
    rd_obs = tcdm_r_data;
  endtask

  task automatic set_port(input int p, input logic rq, input logic wn, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
    tcdm_req[p] = rq; tcdm_wen[p] = wn; tcdm_add[p] = a; tcdm_be[p] = b; tcdm_data[p] = d;
  endtask

  task automatic idle_all();
    for (int p = 0; p < MP; p++) set_port(p, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, 1'($urandom), $urandom, 4'hF, $urandom);
    tick();
    tick();
    checks++; if (gnt_obs !== '0) begin errors++; $display("FAIL reset_gnt got %h want 0", gnt_obs); end
    checks++; if (rv_obs !== '0) begin errors++; $display("FAIL reset_rvalid got %h want 0", rv_obs); end
    checks++; if (rd_obs !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", rd_obs); end
    rst_i = 1'b0;
    idle_all();
  endtask

  // fills rows 0..3 of every bank so later reads are defined
  task automatic test_preload();
    for (int i = 0; i < 32; i++) begin
      set_port(0, 1'b1, 1'b0, 32'(i) << 2, 4'hF, $urandom);
      tick();
      checks++; if (gnt_obs !== exp_gnt) begin errors++; $display("FAIL preload_gnt got %h want %h", gnt_obs, exp_gnt); end
      checks++; if (rv_obs !== exp_rv) begin errors++; $display("FAIL preload_rvalid got %h want %h", rv_obs, exp_rv); end
    end
    idle_all();
  endtask

  task automatic test_write_read();
    set_port(0, 1'b1, 1'b0, 32'h40, 4'hF, 32'hDEADBEEF);
    tick();
    checks++; if (gnt_obs !== 4'b0001) begin errors++; $display("FAIL wr_gnt got %h want 1", gnt_obs); end
    checks++; if (rv_obs !== 4'b0001 || rd_obs[0] !== 32'h0) begin
      errors++; $display("FAIL wr_resp got v=%h d=%h want v=1 d=0", rv_obs, rd_obs[0]); end
    set_port(0, 1'b1, 1'b1, 32'h40, 4'h0, 32'h0);
    tick();
    checks++; if (gnt_obs !== 4'b0001) begin errors++; $display("FAIL rd_gnt got %h want 1", gnt_obs); end
    checks++; if (rv_obs !== 4'b0001 || rd_obs[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_resp got v=%h d=%h want v=1 d=deadbeef", rv_obs, rd_obs[0]); end
    idle_all();
    tick();
    checks++; if (rv_obs !== 4'b0000 || rd_obs[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_hold got v=%h d=%h want v=0 d=deadbeef", rv_obs, rd_obs[0]); end
  endtask

  task automatic test_byte_enable();
    set_port(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h11223344);
    tick();
    set_port(0, 1'b1, 1'b0, 32'h0, 4'b0101, 32'hAABBCCDD);
    tick();
    set_port(0, 1'b1, 1'b1, 32'h0, 4'h0, 32'h0);
    tick();
    checks++; if (rd_obs[0] !== 32'h11BB33DD) begin errors++; $display("FAIL byte_en got %h want 11bb33dd", rd_obs[0]); end
    set_port(0, 1'b1, 1'b0, 32'h0, 4'b0000, 32'hFFFFFFFF);
    tick();
    checks++; if (rv_obs[0] !== 1'b1) begin errors++; $display("FAIL be0_resp got %b want 1", rv_obs[0]); end
    set_port(0, 1'b1, 1'b1, 32'h0, 4'h0, 32'h0);
    tick();
    checks++; if (rd_obs[0] !== 32'h11BB33DD) begin errors++; $display("FAIL be0_nowrite got %h want 11bb33dd", rd_obs[0]); end
    idle_all();
  endtask

  task automatic test_aliasing();
    set_port(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h5A5A5A5A);
    tick();
    set_port(0, 1'b1, 1'b1, 32'h8000, 4'h0, 32'h0);
    tick();
    checks++; if (rd_obs[0] !== 32'h5A5A5A5A) begin errors++; $display("FAIL alias got %h want 5a5a5a5a", rd_obs[0]); end
    idle_all();
  endtask

  task automatic test_parallel();
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, 1'b1, 32'(p) << 2, 4'h0, 32'h0);
    tick();
    checks++; if (gnt_obs !== 4'hF) begin errors++; $display("FAIL par_gnt got %h want f", gnt_obs); end
    checks++; if (rv_obs !== 4'hF) begin errors++; $display("FAIL par_rvalid got %h want f", rv_obs); end
    checks++; if (rd_obs !== exp_rd) begin errors++; $display("FAIL par_rdata got %h want %h", rd_obs, exp_rd); end
    idle_all();
  endtask

  task automatic test_fairness();
    logic [MP-1:0] want;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, 1'b1, 32'h0C, 4'h0, 32'h0);
    for (int c = 0; c < 8; c++) begin
      want = 4'b0001 << (c % MP);
      tick();
      checks++; if (gnt_obs !== want) begin errors++; $display("FAIL rr_gnt c=%0d got %h want %h", c, gnt_obs, want); end
      checks++; if (rv_obs !== want) begin errors++; $display("FAIL rr_rvalid c=%0d got %h want %h", c, rv_obs, want); end
    end
    idle_all();
  endtask

  task automatic test_reset_mid();
    set_port(1, 1'b1, 1'b1, 32'h0C, 4'h0, 32'h0);
    tick();
    idle_all();
    set_port(0, 1'b1, 1'b1, 32'h40, 4'h0, 32'h0);
    tick();
    checks++; if (gnt_obs !== 4'b0001) begin errors++; $display("FAIL mid_gnt got %h want 1", gnt_obs); end
    rst_i = 1'b1;
    tick();
    checks++; if (gnt_obs !== 4'b0000) begin errors++; $display("FAIL mid_rst_gnt got %h want 0", gnt_obs); end
    checks++; if (rv_obs !== '0 || rd_obs !== '0) begin
      errors++; $display("FAIL mid_rst_resp got v=%h d=%h want 0", rv_obs, rd_obs); end
    rst_i = 1'b0;
    for (int p = 0; p < MP; p++) set_port(p, 1'b1, 1'b1, 32'h0C, 4'h0, 32'h0);
    tick();
    checks++; if (gnt_obs !== 4'b0001) begin errors++; $display("FAIL mid_rr_restart got %h want 1", gnt_obs); end
    idle_all();
  endtask

  // requesters hold a transaction until granted; addresses alias onto the preloaded pool
  task automatic test_random();
    for (int p = 0; p < MP; p++) tcdm_req[p] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < MP; p++)
        if (!tcdm_req[p] || exp_gnt[p])
          set_port(p, 1'($urandom_range(0, 3) != 0), 1'($urandom),
                   (32'($urandom_range(0, 31)) << 2) | ($urandom & 32'hFFFF_8003),
                   4'($urandom), $urandom);
      tick();
      checks++; if (gnt_obs !== exp_gnt) begin errors++; $display("FAIL rnd_gnt c=%0d got %h want %h", c, gnt_obs, exp_gnt); end
      checks++; if (rv_obs !== exp_rv) begin errors++; $display("FAIL rnd_rvalid c=%0d got %h want %h", c, rv_obs, exp_rv); end
      checks++; if (rd_obs !== exp_rd) begin errors++; $display("FAIL rnd_rdata c=%0d got %h want %h", c, rd_obs, exp_rd); end
    end
    idle_all();
  endtask

  initial begin
    exp_gnt = '0;
    exp_rv  = '0;
    exp_rd  = '0;
    for (int b = 0; b < NB; b++) rr[b] = 0;
    test_reset();
    test_preload();
    test_write_read();
    test_byte_enable();
    test_aliasing();
    test_parallel();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
